// File: rtl/mac_array_datapath_if.sv
// Operand/result bundle between the conv controller, external memory and the MAC array.
// Latency: none, this is wiring only.
// Backpressure: none; the array accepts one operand set per cycle.
interface mac_array_datapath_if #(
   parameter int IO_DATA_WIDTH      = 16,
   parameter int ACCUMULATION_WIDTH = 32,
   parameter int NB_LANES           = 4,
   parameter int ADDR_WIDTH         = 20,
   parameter int SHIFT_WIDTH        = $clog2(ACCUMULATION_WIDTH)
);
   logic                                   in_valid;
   logic [IO_DATA_WIDTH-1:0]               a_in;
   logic [NB_LANES*IO_DATA_WIDTH-1:0]      b_in;
   logic [1:0]                             acc_mode;
   logic                                   wb_en;
   logic [ADDR_WIDTH-1:0]                  wb_addr;
   logic [NB_LANES*ACCUMULATION_WIDTH-1:0] psum_in;
   logic [SHIFT_WIDTH-1:0]                 out_shift;
   logic                                   clear_overflow;
   logic                                   out_valid;
   logic [ADDR_WIDTH-1:0]                  out_addr;
   logic [NB_LANES*ACCUMULATION_WIDTH-1:0] acc_out;
   logic [NB_LANES*IO_DATA_WIDTH-1:0]      q_out;
   logic                                   overflow;

   modport master (
      output in_valid, a_in, b_in, acc_mode, wb_en, wb_addr, psum_in, out_shift, clear_overflow,
      input  out_valid, out_addr, acc_out, q_out, overflow
   );

   modport slave (
      input  in_valid, a_in, b_in, acc_mode, wb_en, wb_addr, psum_in, out_shift, clear_overflow,
      output out_valid, out_addr, acc_out, q_out, overflow
   );
endinterface

// File: rtl/mac_array_datapath.sv
// NB_LANES signed MAC lanes sharing one activation, with aligned external psum and per-lane requantisation.
// Latency: PSUM_LATENCY+2 cycles from in_valid to out_valid / acc update.
// Backpressure: none; one operation accepted every cycle, bubbles pass through as valid=0.
module mac_array_datapath #(
   parameter int IO_DATA_WIDTH      = 16,
   parameter int ACCUMULATION_WIDTH = 32,
   parameter int NB_LANES           = 4,
   parameter int PSUM_LATENCY       = 1,
   parameter int ADDR_WIDTH         = 20,
   parameter int SHIFT_WIDTH        = $clog2(ACCUMULATION_WIDTH)
) (
   input logic               clk,
   input logic               arst_n_in,
   mac_array_datapath_if.slave bus
);
   localparam int IW = IO_DATA_WIDTH;
   localparam int AW = ACCUMULATION_WIDTH;
   localparam int PW = 2 * IO_DATA_WIDTH;
   localparam int L  = PSUM_LATENCY;

   typedef struct packed {
      logic                  vld;
      logic [1:0]            mode;
      logic                  wb;
      logic [ADDR_WIDTH-1:0] addr;
      logic [IW-1:0]         a;
      logic [NB_LANES*IW-1:0] b;
   } dline_t;

   dline_t dl_in;
   dline_t dl [L];
   dline_t dal;

   logic signed [IW-1:0] a_s;
   logic signed [IW-1:0] b_s      [NB_LANES];
   logic signed [PW-1:0] mul_full [NB_LANES];

   logic                  p_vld;
   logic                  p_wb;
   logic                  p_use_acc;
   logic [ADDR_WIDTH-1:0] p_addr;
   logic signed [AW-1:0]  prod [NB_LANES];
   logic signed [AW-1:0]  base [NB_LANES];

   logic signed [AW-1:0]  acc     [NB_LANES];
   logic signed [AW-1:0]  opnd    [NB_LANES];
   logic signed [AW-1:0]  sum     [NB_LANES];
   logic [NB_LANES-1:0]   lane_ovf;
   logic signed [AW-1:0]  shifted [NB_LANES];
   logic [IW-1:0]         q_lane  [NB_LANES];
   logic [SHIFT_WIDTH-1:0] shamt;

   // Pack the incoming operand set into one delay-line record.
   always_comb begin
      dl_in      = '0;
      dl_in.vld  = bus.in_valid;
      dl_in.mode = bus.acc_mode;
      dl_in.wb   = bus.wb_en;
      dl_in.addr = bus.wb_addr;
      dl_in.a    = bus.a_in;
      dl_in.b    = bus.b_in;
   end

   // Delay line: operands move only with a valid, bubbles just clear the valid bit.
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         for (int s = 0; s < L; s++) dl[s] <= '0;
      end else begin
         if (dl_in.vld) dl[0] <= dl_in;
         else           dl[0].vld <= 1'b0;
         for (int s = 1; s < L; s++) begin
            if (dl[s-1].vld) dl[s] <= dl[s-1];
            else             dl[s].vld <= 1'b0;
         end
      end
   end

   assign dal = dl[L-1];

   // Full-precision signed products of the aligned operand set.
   always_comb begin
      a_s = dal.a;
      for (int i = 0; i < NB_LANES; i++) begin
         b_s[i]      = dal.b[i*IW +: IW];
         mul_full[i] = PW'(a_s) * PW'(b_s[i]);
      end
   end

   // Product/base stage: psum_in is sampled here and only for a valid mode-2 op.
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         p_vld     <= 1'b0;
         p_wb      <= 1'b0;
         p_use_acc <= 1'b0;
         p_addr    <= '0;
         for (int i = 0; i < NB_LANES; i++) begin
            prod[i] <= '0;
            base[i] <= '0;
         end
      end else begin
         p_vld <= dal.vld;
         if (dal.vld) begin
            p_wb      <= dal.wb;
            p_addr    <= dal.addr;
            p_use_acc <= dal.mode[0];
            for (int i = 0; i < NB_LANES; i++) begin
               prod[i] <= AW'(mul_full[i]);
               base[i] <= (dal.mode == 2'd2) ? $signed(bus.psum_in[i*AW +: AW]) : '0;
            end
         end
      end
   end

   // Adder feedback reads acc directly so back-to-back accumulation sees last cycle's sum.
   always_comb begin
      for (int i = 0; i < NB_LANES; i++) begin
         opnd[i]     = p_use_acc ? acc[i] : base[i];
         sum[i]      = opnd[i] + prod[i];
         lane_ovf[i] = (opnd[i][AW-1] == prod[i][AW-1]) && (sum[i][AW-1] != opnd[i][AW-1]);
      end
   end

   // Accumulate stage with sticky overflow; a new overflow beats a simultaneous clear.
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         bus.out_valid <= 1'b0;
         bus.out_addr  <= '0;
         bus.overflow  <= 1'b0;
         for (int i = 0; i < NB_LANES; i++) acc[i] <= '0;
      end else begin
         bus.out_valid <= p_vld & p_wb;
         bus.overflow  <= (p_vld & (|lane_ovf)) | (bus.overflow & ~bus.clear_overflow);
         if (p_vld) begin
            bus.out_addr <= p_addr;
            for (int i = 0; i < NB_LANES; i++) acc[i] <= sum[i];
         end
      end
   end

   assign shamt = bus.out_shift;

   // Requantise: arithmetic shift, then clamp when the dropped high bits are not pure sign.
   always_comb begin
      for (int i = 0; i < NB_LANES; i++) begin
         shifted[i] = acc[i] >>> shamt;
         if ((&shifted[i][AW-1:IW-1]) || !(|shifted[i][AW-1:IW-1]))
            q_lane[i] = shifted[i][IW-1:0];
         else if (shifted[i][AW-1])
            q_lane[i] = {1'b1, {(IW-1){1'b0}}};
         else
            q_lane[i] = {1'b0, {(IW-1){1'b1}}};
      end
   end

   for (genvar g = 0; g < NB_LANES; g++) begin : g_lane
      assign bus.acc_out[g*AW +: AW] = acc[g];
      assign bus.q_out[g*IW +: IW]   = q_lane[g];
   end
endmodule

// File: tb/tb_mac_array_datapath.sv
// Directed bench for mac_array_datapath: table vectors on an L=1 array plus multi-cycle sequences and an L=3 array.
// Latency: expects results L+2 cycles after each operand set.
// Backpressure: none exercised; the array has no ready.
module tb_mac_array_datapath;
   localparam int IW  = 16;
   localparam int AW  = 32;
   localparam int NL  = 4;
   localparam int ADW = 20;
   localparam int SW  = 5;

   logic clk = 1'b0;
   logic arst_n = 1'b0;
   always #5 clk = ~clk;

   mac_array_datapath_if #(.IO_DATA_WIDTH(IW), .ACCUMULATION_WIDTH(AW), .NB_LANES(NL),
                           .ADDR_WIDTH(ADW), .SHIFT_WIDTH(SW)) m1 ();
   mac_array_datapath_if #(.IO_DATA_WIDTH(IW), .ACCUMULATION_WIDTH(AW), .NB_LANES(NL),
                           .ADDR_WIDTH(ADW), .SHIFT_WIDTH(SW)) m3 ();

   mac_array_datapath #(.IO_DATA_WIDTH(IW), .ACCUMULATION_WIDTH(AW), .NB_LANES(NL),
                        .PSUM_LATENCY(1), .ADDR_WIDTH(ADW), .SHIFT_WIDTH(SW))
      dut1 (.clk(clk), .arst_n_in(arst_n), .bus(m1.slave));
   mac_array_datapath #(.IO_DATA_WIDTH(IW), .ACCUMULATION_WIDTH(AW), .NB_LANES(NL),
                        .PSUM_LATENCY(3), .ADDR_WIDTH(ADW), .SHIFT_WIDTH(SW))
      dut3 (.clk(clk), .arst_n_in(arst_n), .bus(m3.slave));

   typedef struct {
      logic [IW-1:0]         a;
      logic [NL-1:0][IW-1:0] b;
      logic [1:0]            mode;
      logic [NL-1:0][AW-1:0] psum;
      logic [SW-1:0]         shift;
      logic [NL-1:0][AW-1:0] exp_acc;
      logic [NL-1:0][IW-1:0] exp_q;
   } vec_t;

   vec_t vt [7];
   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle1();
      m1.in_valid = 1'b0;
      m1.wb_en    = 1'b0;
      m1.acc_mode = 2'($urandom);
      m1.a_in     = 16'($urandom);
      m1.b_in     = {$urandom, $urandom};
      m1.wb_addr  = 20'($urandom);
      m1.psum_in  = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic idle3();
      m3.in_valid = 1'b0;
      m3.wb_en    = 1'b0;
      m3.acc_mode = 2'($urandom);
      m3.a_in     = 16'($urandom);
      m3.b_in     = {$urandom, $urandom};
      m3.wb_addr  = 20'($urandom);
      m3.psum_in  = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic drive1(input logic [IW-1:0] a, input logic [NL*IW-1:0] b, input logic [1:0] mode,
                         input logic wb, input logic [ADW-1:0] addr);
      m1.in_valid = 1'b1;
      m1.a_in     = a;
      m1.b_in     = b;
      m1.acc_mode = mode;
      m1.wb_en    = wb;
      m1.wb_addr  = addr;
      m1.psum_in  = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // Nine ops of a=2,b=3 (first mode 0), optional bubble, wb only on the ninth.
   task automatic run_stream(input int bubble_at, input logic [1:0] amode,
                             output int pulses, output int pulse_cyc, output logic [NL*AW-1:0] seen);
      int j = 0;
      pulses = 0;
      pulse_cyc = -1;
      seen = '0;
      for (int n = 0; n < 18; n++) begin
         if (n == bubble_at || j >= 9) idle1();
         else begin
            drive1(16'd2, {4{16'd3}}, (j == 0) ? 2'd0 : amode, j == 8, 20'h00200 + 20'(j));
            j++;
         end
         tick();
         if (m1.out_valid) begin
            pulses++;
            pulse_cyc = n;
            seen = m1.acc_out;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit expired before the bench finished");
      $fatal(1);
   end

   initial begin
      int pulses, pcyc, outs;
      logic [NL*AW-1:0] seen;

      vt[0] = '{a: 16'd3, b: {16'sd0, 16'sd5, -16'sd4, 16'sd2}, mode: 2'd0,
                psum: {4{32'h5555_5555}}, shift: 5'd0,
                exp_acc: {32'sd0, 32'sd15, -32'sd12, 32'sd6},
                exp_q: {16'sd0, 16'sd15, -16'sd12, 16'sd6}};
      vt[1] = '{a: 16'd0, b: {4{16'd0}}, mode: 2'd2,
                psum: {32'sd100, -32'sd1, -32'sd70000, 32'sd65536}, shift: 5'd0,
                exp_acc: {32'sd100, -32'sd1, -32'sd70000, 32'sd65536},
                exp_q: {16'sd100, -16'sd1, 16'h8000, 16'sd32767}};
      vt[2] = '{a: 16'd0, b: {4{16'd0}}, mode: 2'd2,
                psum: {32'sd100, -32'sd1, -32'sd70000, 32'sd65536}, shift: 5'd4,
                exp_acc: {32'sd100, -32'sd1, -32'sd70000, 32'sd65536},
                exp_q: {16'sd6, -16'sd1, -16'sd4375, 16'sd4096}};
      vt[3] = '{a: -16'sd7, b: {-16'sd300, 16'sd300, -16'sd1, 16'sd1}, mode: 2'd2,
                psum: {32'sd40, -32'sd30, 32'sd20, 32'sd10}, shift: 5'd0,
                exp_acc: {32'sd2140, -32'sd2130, 32'sd27, 32'sd3},
                exp_q: {16'sd2140, -16'sd2130, 16'sd27, 16'sd3}};
      vt[4] = '{a: 16'h8000, b: {16'sd0, 16'sd1, 16'sd32767, 16'h8000}, mode: 2'd0,
                psum: {4{32'hA5A5_A5A5}}, shift: 5'd16,
                exp_acc: {32'sd0, -32'sd32768, -32'sd1073709056, 32'h4000_0000},
                exp_q: {16'sd0, -16'sd1, -16'sd16384, 16'sd16384}};
      vt[5] = '{a: 16'sd10, b: {4{-16'sd5}}, mode: 2'd2,
                psum: {4{32'sd1000}}, shift: 5'd0,
                exp_acc: {4{32'sd950}}, exp_q: {4{16'sd950}}};
      vt[6] = '{a: 16'sd1, b: {16'sd4, 16'sd3, 16'sd2, 16'sd1}, mode: 2'd1,
                psum: {4{32'h7FFF_FFFF}}, shift: 5'd1,
                exp_acc: {32'sd954, 32'sd953, 32'sd952, 32'sd951},
                exp_q: {16'sd477, 16'sd476, 16'sd476, 16'sd475}};

      m1.out_shift = '0;  m1.clear_overflow = 1'b0;
      m3.out_shift = '0;  m3.clear_overflow = 1'b0;
      idle1();
      idle3();

      // Reset held while inputs toggle.
      for (int c = 0; c < 4; c++) begin
         drive1(16'($urandom), {$urandom, $urandom}, 2'($urandom), 1'($urandom), 20'($urandom));
         m1.in_valid = 1'($urandom);
         tick();
         check("rst_out_valid", {31'b0, m1.out_valid}, 32'd0);
         check("rst_acc_out", {31'b0, |m1.acc_out}, 32'd0);
         check("rst_q_out", {31'b0, |m1.q_out}, 32'd0);
         check("rst_out_addr", {12'b0, m1.out_addr}, 32'd0);
         check("rst_overflow", {31'b0, m1.overflow}, 32'd0);
      end
      idle1();
      arst_n = 1'b1;
      tick();
      check("rel_out_valid", {31'b0, m1.out_valid}, 32'd0);
      check("rel_acc_out", {31'b0, |m1.acc_out}, 32'd0);
      check("rel_q_out", {31'b0, |m1.q_out}, 32'd0);
      check("rel_overflow", {31'b0, m1.overflow}, 32'd0);
      for (int c = 0; c < 4; c++) tick();

      // Table vectors, one wb op each, psum present only in the aligned cycle.
      for (int k = 0; k < 7; k++) begin
         m1.out_shift = vt[k].shift;
         drive1(vt[k].a, vt[k].b, vt[k].mode, 1'b1, 20'h00010 + 20'(k));
         tick();
         idle1();
         m1.psum_in = vt[k].psum;
         tick();
         idle1();
         tick();
         check($sformatf("vec%0d_out_valid", k), {31'b0, m1.out_valid}, 32'd1);
         check($sformatf("vec%0d_out_addr", k), {12'b0, m1.out_addr}, 32'h10 + 32'(k));
         for (int i = 0; i < NL; i++) begin
            check($sformatf("vec%0d_acc_l%0d", k, i), m1.acc_out[i*AW +: AW], vt[k].exp_acc[i]);
            check($sformatf("vec%0d_q_l%0d", k, i), {16'b0, m1.q_out[i*IW +: IW]}, {16'b0, vt[k].exp_q[i]});
         end
         tick();
         check($sformatf("vec%0d_pulse_end", k), {31'b0, m1.out_valid}, 32'd0);
      end
      m1.out_shift = '0;

      // Nine-op internal accumulation, without and with a bubble (mode 3 in the second run).
      run_stream(-1, 2'd1, pulses, pcyc, seen);
      check("stream_pulses", 32'(pulses), 32'd1);
      check("stream_pulse_cycle", 32'(pcyc), 32'd10);
      for (int i = 0; i < NL; i++) check($sformatf("stream_acc_l%0d", i), seen[i*AW +: AW], 32'd54);
      run_stream(4, 2'd3, pulses, pcyc, seen);
      check("bubble_pulses", 32'(pulses), 32'd1);
      check("bubble_pulse_cycle", 32'(pcyc), 32'd11);
      for (int i = 0; i < NL; i++) check($sformatf("bubble_acc_l%0d", i), seen[i*AW +: AW], 32'd54);

      // L=3 array: psum must be taken three cycles after in_valid.
      m3.in_valid = 1'b1;  m3.a_in = 16'sd10;  m3.b_in = {4{-16'sd5}};
      m3.acc_mode = 2'd2;  m3.wb_en = 1'b1;    m3.wb_addr = 20'h00033;
      m3.psum_in = {4{32'h1234_5678}};
      for (int k = 1; k <= 5; k++) begin
         tick();
         idle3();
         if (k == 3) m3.psum_in = {4{32'sd1000}};
         if (k == 4) check("l3_early_valid", {31'b0, m3.out_valid}, 32'd0);
         if (k == 5) begin
            check("l3_out_valid", {31'b0, m3.out_valid}, 32'd1);
            check("l3_out_addr", {12'b0, m3.out_addr}, 32'h33);
            for (int i = 0; i < NL; i++) check($sformatf("l3_acc_l%0d", i), m3.acc_out[i*AW +: AW], 32'd950);
         end
      end

      // Overflow: positive wrap, hold, set-beats-clear, then clear alone.
      check("ovf_initial", {31'b0, m1.overflow}, 32'd0);
      drive1(16'sd1, {4{16'sd1}}, 2'd2, 1'b1, 20'h00040);
      tick();
      idle1();
      m1.psum_in = {32'd0, 32'd0, 32'd0, 32'h7FFF_FFFF};
      tick();
      idle1();
      tick();
      check("ovf_acc_l0", m1.acc_out[0 +: AW], 32'h8000_0000);
      check("ovf_acc_l1", m1.acc_out[AW +: AW], 32'd1);
      check("ovf_set", {31'b0, m1.overflow}, 32'd1);
      tick();
      tick();
      check("ovf_hold", {31'b0, m1.overflow}, 32'd1);
      drive1(16'hFFFF, {4{16'sd1}}, 2'd1, 1'b1, 20'h00041);
      tick();
      idle1();
      tick();
      m1.clear_overflow = 1'b1;
      tick();
      m1.clear_overflow = 1'b0;
      check("ovf_neg_wrap_l0", m1.acc_out[0 +: AW], 32'h7FFF_FFFF);
      check("ovf_neg_wrap_l1", m1.acc_out[AW +: AW], 32'd0);
      check("ovf_set_beats_clear", {31'b0, m1.overflow}, 32'd1);
      m1.clear_overflow = 1'b1;
      tick();
      m1.clear_overflow = 1'b0;
      check("ovf_cleared", {31'b0, m1.overflow}, 32'd0);
      tick();
      check("ovf_stays_clear", {31'b0, m1.overflow}, 32'd0);

      // Reset with three wb ops in flight: none may emerge afterwards.
      drive1(16'sd1, {4{16'sd1}}, 2'd0, 1'b1, 20'h00050);
      tick();
      drive1(16'sd1, {4{16'sd1}}, 2'd0, 1'b1, 20'h00051);
      tick();
      drive1(16'sd1, {4{16'sd1}}, 2'd0, 1'b1, 20'h00052);
      #2;
      arst_n = 1'b0;
      #1;
      check("midrst_out_valid", {31'b0, m1.out_valid}, 32'd0);
      check("midrst_acc_l0", m1.acc_out[0 +: AW], 32'd0);
      idle1();
      tick();
      arst_n = 1'b1;
      outs = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (m1.out_valid) outs++;
      end
      check("midrst_no_out_valid", 32'(outs), 32'd0);
      check("midrst_acc_after", {31'b0, |m1.acc_out}, 32'd0);
      check("midrst_addr_after", {12'b0, m1.out_addr}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
